// File: rtl/rv32i_multicycle_ctrl_if.sv
// rv32i_multicycle_ctrl_if: controller <-> datapath bundle for the multicycle RV32I core
//   master (controller): reads op/funct3/funct7b5/Zero/mem_ready, drives control strobes and selects
//   slave  (datapath)  : drives instruction fields, ALU flag and memory ready, consumes controls
interface rv32i_multicycle_ctrl_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [2:0] ALUControl;
  logic       trap;
  modport master (
    input  op, funct3, funct7b5, Zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, trap
  );
  modport slave (
    output op, funct3, funct7b5, Zero, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, trap
  );
endinterface

// File: rtl/rv32i_multicycle_ctrl.sv
// rv32i_multicycle_ctrl: Moore control FSM for a multicycle RV32I datapath
//   clk   : rising-edge clock
//   reset : synchronous, active-low reset (forces write enables low while asserted)
//   bus   : master side of rv32i_multicycle_ctrl_if (instruction fields, Zero, mem_ready in;
//           PCWrite/AdrSrc/MemWrite/IRWrite/RegWrite/ResultSrc/ALUSrcA/ALUSrcB/ImmSrc/ALUControl/trap out)
module rv32i_multicycle_ctrl #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  rv32i_multicycle_ctrl_if.master       bus
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, ILLEGAL
  } state_t;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  state_t     state, state_n;
  logic       rdy;
  logic       pc_w, ir_w, mem_w, reg_w;
  logic [1:0] alu_op;
  logic [2:0] funct_ctl;
  assign rdy = MEM_WAIT_EN ? bus.mem_ready : 1'b1;
  always_ff @(posedge clk)
    if (!reset) state <= FETCH;
    else        state <= state_n;
  always_comb begin
    state_n = FETCH;
    case (state)
      FETCH:    state_n = rdy ? DECODE : FETCH;
      DECODE:   state_n = (bus.op == OP_LW || bus.op == OP_SW) ? MEMADR   :
                          (bus.op == OP_R)                      ? EXECUTER :
                          (bus.op == OP_I)                      ? EXECUTEI :
                          (bus.op == OP_BEQ)                    ? BEQ      :
                          (bus.op == OP_JAL)                    ? JAL      : ILLEGAL;
      MEMADR:   state_n = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  state_n = rdy ? MEMWB : MEMREAD;
      MEMWRITE: state_n = rdy ? FETCH : MEMWRITE;
      MEMWB:    state_n = FETCH;
      EXECUTER: state_n = ALUWB;
      EXECUTEI: state_n = ALUWB;
      ALUWB:    state_n = FETCH;
      BEQ:      state_n = FETCH;
      JAL:      state_n = ALUWB;
      ILLEGAL:  state_n = ILLEGAL;
      default:  state_n = FETCH;
    endcase
  end
  always_comb begin
    pc_w          = 1'b0;
    ir_w          = 1'b0;
    mem_w         = 1'b0;
    reg_w         = 1'b0;
    alu_op        = ALU_ADD;
    bus.AdrSrc    = 1'b0;
    bus.ResultSrc = 2'b00;
    bus.ALUSrcA   = 2'b00;
    bus.ALUSrcB   = 2'b00;
    case (state)
      FETCH: begin
        ir_w          = rdy;
        pc_w          = rdy;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
      end
      DECODE: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b01;
      end
      MEMADR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
      end
      MEMREAD:  bus.AdrSrc = 1'b1;
      MEMWRITE: begin
        bus.AdrSrc = 1'b1;
        mem_w      = 1'b1;
      end
      MEMWB: begin
        bus.ResultSrc = 2'b01;
        reg_w         = 1'b1;
      end
      EXECUTER: begin
        bus.ALUSrcA = 2'b10;
        alu_op      = ALU_FUNCT;
      end
      EXECUTEI: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        alu_op      = ALU_FUNCT;
      end
      ALUWB: reg_w = 1'b1;
      BEQ: begin
        bus.ALUSrcA = 2'b10;
        alu_op      = ALU_SUB;
        pc_w        = bus.Zero;
      end
      JAL: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b10;
        pc_w        = 1'b1;
      end
      default: ;
    endcase
  end
  // op[5] separates R-type (sub possible) from I-type, where bit 30 is immediate data
  assign funct_ctl = (bus.funct3 == 3'b000) ? ((bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000) :
                     (bus.funct3 == 3'b010) ? 3'b101 :
                     (bus.funct3 == 3'b110) ? 3'b011 :
                     (bus.funct3 == 3'b111) ? 3'b010 : 3'b000;
  assign bus.ALUControl = (alu_op == ALU_SUB)   ? 3'b001    :
                          (alu_op == ALU_FUNCT) ? funct_ctl : 3'b000;
  assign bus.ImmSrc = (bus.op == OP_SW)  ? 2'b01 :
                      (bus.op == OP_BEQ) ? 2'b10 :
                      (bus.op == OP_JAL) ? 2'b11 : 2'b00;
  // enables are masked while reset is held so an abandoned instruction cannot write
  assign bus.PCWrite  = reset & pc_w;
  assign bus.IRWrite  = reset & ir_w;
  assign bus.MemWrite = reset & mem_w;
  assign bus.RegWrite = reset & reg_w;
  assign bus.trap     = reset & (state == ILLEGAL);
endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// tb_rv32i_multicycle_ctrl: directed checks of the multicycle control FSM output sequences
module tb_rv32i_multicycle_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  rv32i_multicycle_ctrl_if bus ();
  rv32i_multicycle_ctrl #(.MEM_WAIT_EN(1'b1)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic pcw, input logic adr, input logic mw,
                     input logic irw, input logic rw, input logic [1:0] rs, input logic [1:0] sa,
                     input logic [1:0] sb, input logic [1:0] im, input logic [2:0] al, input logic tp);
    logic [16:0] obs, exp;
    #1;
    obs = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.ResultSrc,
           bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.ALUControl, bus.trap};
    exp = {pcw, adr, mw, irw, rw, rs, sa, sb, im, al, tp};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  initial begin
    reset = 1'b0;
    bus.op = 7'b0110011; bus.funct3 = 3'b000; bus.funct7b5 = 1'b1;
    bus.Zero = 1'b0; bus.mem_ready = 1'b1;
    tick();
    chk("rst_fetch_masked", 0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,3'b000,0);
    tick();
    reset = 1'b1;
    chk("r_fetch",    1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00,3'b000,0);
    tick(); chk("r_decode",   0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,3'b000,0);
    tick(); chk("r_execute",  0,0,0,0,0, 2'b00,2'b10,2'b00,2'b00,3'b001,0);
    tick(); chk("r_aluwb",    0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00,3'b000,0);
    tick();
    bus.op = 7'b0000011; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0;
    chk("lw_fetch",   1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00,3'b000,0);
    tick(); chk("lw_decode",  0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,3'b000,0);
    tick(); chk("lw_memadr",  0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00,3'b000,0);
    tick(); bus.mem_ready = 1'b0;
    chk("lw_memread1", 0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,3'b000,0);
    tick(); chk("lw_memread2", 0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,3'b000,0);
    tick(); bus.mem_ready = 1'b1;
    chk("lw_memread3", 0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,3'b000,0);
    tick(); chk("lw_memwb",   0,0,0,0,1, 2'b01,2'b00,2'b00,2'b00,3'b000,0);
    tick();
    bus.op = 7'b0100011;
    chk("sw_fetch",   1,0,0,1,0, 2'b10,2'b00,2'b10,2'b01,3'b000,0);
    tick(); chk("sw_decode",  0,0,0,0,0, 2'b00,2'b01,2'b01,2'b01,3'b000,0);
    tick(); chk("sw_memadr",  0,0,0,0,0, 2'b00,2'b10,2'b01,2'b01,3'b000,0);
    tick(); chk("sw_memwrite",0,1,1,0,0, 2'b00,2'b00,2'b00,2'b01,3'b000,0);
    tick();
    bus.op = 7'b1100011; bus.funct3 = 3'b000; bus.Zero = 1'b1;
    chk("beq_fetch",  1,0,0,1,0, 2'b10,2'b00,2'b10,2'b10,3'b000,0);
    tick(); chk("beq_decode", 0,0,0,0,0, 2'b00,2'b01,2'b01,2'b10,3'b000,0);
    tick(); chk("beq_taken",  1,0,0,0,0, 2'b00,2'b10,2'b00,2'b10,3'b001,0);
    bus.Zero = 1'b0;
    chk("beq_not_taken", 0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10,3'b001,0);
    tick();
    bus.op = 7'b1101111;
    chk("jal_fetch",  1,0,0,1,0, 2'b10,2'b00,2'b10,2'b11,3'b000,0);
    tick(); chk("jal_decode", 0,0,0,0,0, 2'b00,2'b01,2'b01,2'b11,3'b000,0);
    tick(); chk("jal_jal",    1,0,0,0,0, 2'b00,2'b01,2'b10,2'b11,3'b000,0);
    tick(); chk("jal_aluwb",  0,0,0,0,1, 2'b00,2'b00,2'b00,2'b11,3'b000,0);
    tick();
    bus.op = 7'b0010011; bus.funct3 = 3'b000; bus.funct7b5 = 1'b1;
    chk("i_fetch",    1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00,3'b000,0);
    tick(); tick();
    chk("i_addi_b30", 0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00,3'b000,0);
    bus.funct3 = 3'b010;
    chk("i_slti",     0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00,3'b101,0);
    bus.funct3 = 3'b110;
    chk("i_ori",      0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00,3'b011,0);
    bus.funct3 = 3'b111;
    chk("i_andi",     0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00,3'b010,0);
    bus.funct3 = 3'b001;
    chk("i_other",    0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00,3'b000,0);
    tick(); chk("i_aluwb",    0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00,3'b000,0);
    tick();
    bus.op = 7'b1111111; bus.funct3 = 3'b000;
    chk("ill_fetch",  1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00,3'b000,0);
    tick(); chk("ill_decode", 0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00,3'b000,0);
    for (int i = 0; i < 10; i++) begin
      tick();
      bus.mem_ready = i[0]; bus.Zero = ~i[0];
      chk($sformatf("ill_hold%0d", i), 0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,3'b000,1);
    end
    bus.mem_ready = 1'b1; bus.Zero = 1'b0;
    reset = 1'b0;
    chk("ill_rst_trap0", 0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,3'b000,0);
    tick();
    chk("ill_rst_fetch", 0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,3'b000,0);
    reset = 1'b1;
    bus.op = 7'b0100011;
    chk("sw2_fetch",  1,0,0,1,0, 2'b10,2'b00,2'b10,2'b01,3'b000,0);
    tick(); tick(); tick();
    bus.mem_ready = 1'b0;
    chk("sw2_memwrite", 0,1,1,0,0, 2'b00,2'b00,2'b00,2'b01,3'b000,0);
    tick(); chk("sw2_memwrite_wait", 0,1,1,0,0, 2'b00,2'b00,2'b00,2'b01,3'b000,0);
    reset = 1'b0;
    chk("sw2_rst_mask", 0,1,0,0,0, 2'b00,2'b00,2'b00,2'b01,3'b000,0);
    tick();
    chk("sw2_rst_fetch", 0,0,0,0,0, 2'b10,2'b00,2'b10,2'b01,3'b000,0);
    reset = 1'b1;
    chk("fetch_not_ready", 0,0,0,0,0, 2'b10,2'b00,2'b10,2'b01,3'b000,0);
    tick(); chk("fetch_wait", 0,0,0,0,0, 2'b10,2'b00,2'b10,2'b01,3'b000,0);
    bus.mem_ready = 1'b1;
    chk("fetch_ready", 1,0,0,1,0, 2'b10,2'b00,2'b10,2'b01,3'b000,0);
    tick(); chk("fetch_to_decode", 0,0,0,0,0, 2'b00,2'b01,2'b01,2'b01,3'b000,0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv32i_multicycle_ctrl.md
Name: rv32i_multicycle_ctrl

Overview:
- Moore-style control FSM that sequences a multicycle RV32I datapath: shared instruction/data memory, single ALU, and the IR, OldPC, Data and ALUOut registers.
- Companion to the single-cycle core's decoder; the memory interface and the ALU/immediate encodings are unchanged.
- Adds a memory-ready handshake and a sticky illegal-instruction trap.

Parameters:
- MEM_WAIT_EN, 1, when 1 memory states wait for mem_ready; when 0 mem_ready is ignored (treated as 1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- op  input  7  instr[6:0] from IR.
- funct3  input  3  instr[14:12].
- funct7b5  input  1  instr[30].
- Zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes the current access this cycle.
- PCWrite  output  1  PC register enable.
- AdrSrc  output  1  memory address select: 0=PC, 1=Result.
- MemWrite  output  1  memory write strobe.
- IRWrite  output  1  IR and OldPC enable.
- RegWrite  output  1  register file write enable.
- ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult.
- ALUSrcA  output  2  00=PC, 01=OldPC, 10=rd1.
- ALUSrcB  output  2  00=rd2, 01=imm, 10=const 4.
- ImmSrc  output  2  00=I, 01=S, 10=B, 11=J.
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- trap  output  1  sticky illegal-opcode flag.

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, ILLEGAL. The state register is the only flop.
- Reset: reset low at a clock edge gives state=FETCH.
- While reset is low, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0 combinationally; trap=0.
- Mid-instruction reset abandons the instruction; no partial write is issued after the reset edge.
- FETCH: AdrSrc=0, IRWrite=mem_ready, ALUSrcA=00, ALUSrcB=10, ALUOp=add, ResultSrc=10, PCWrite=mem_ready. Stays in FETCH until mem_ready=1, then goes to DECODE. PC+4 and the IR load happen in the same ready cycle.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=add (branch target into ALUOut). Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1100011 → BEQ
  - 1101111 → JAL
  - any other op → ILLEGAL
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Next state is MEMREAD if op=lw, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Waits on mem_ready, then MEMWB.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held every cycle until mem_ready. Then FETCH.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=funct, then ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=funct, then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=sub, ResultSrc=00. PCWrite=Zero (same cycle, combinational). Then FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, then ALUWB (rd=PC+4).
- ILLEGAL: absorbing state. trap=1, all enables 0. Exit only by reset.
- ImmSrc is decoded from op in every state (lw/I-type→00, sw→01, beq→10, jal→11, other→00).
- ALU decode:
  - ALUOp=add gives 000; ALUOp=sub gives 001.
  - funct3 000 gives 001 only if op[5]&funct7b5 (R-type sub), else 000.
  - funct3 010→101, 110→011, 111→010.
  - Other funct3 values map to 000 and do not trap.
- Latency with mem_ready always 1:
  - lw 5 cycles
  - sw, R-type, I-type, jal 4 cycles
  - beq 3 cycles
  - Each cycle mem_ready=0 adds one cycle in FETCH, MEMREAD or MEMWRITE.
- Default for every output not listed in a state: 0.

Test Plan:
- Reset low 2 cycles, then high, op=0110011, funct3=000, funct7b5=1, mem_ready=1 → FETCH(IRWrite=1, PCWrite=1) → DECODE → EXECUTER with ALUControl=001 → ALUWB with RegWrite=1; 4 cycles total.
- op=0000011, mem_ready low for the first 2 MEMREAD cycles → MEMREAD held 3 cycles with AdrSrc=1; MEMWB has ResultSrc=01, RegWrite=1; 7 cycles total.
- op=0100011 → MEMWRITE asserts MemWrite=1, AdrSrc=1 for exactly one cycle; ImmSrc=01 throughout.
- op=1100011 with Zero=1 and then with Zero=0 → BEQ PCWrite=1 and 0 respectively; ALUControl=001; ImmSrc=10.
- op=1111111 → ILLEGAL, trap=1, no enables for 10 cycles. Reset low one edge → trap=0, state FETCH.
- Reset driven low during MEMWRITE with mem_ready=0 → MemWrite=0 immediately; next edge goes to FETCH.
